// File: rtl/instruction_fetch.sv
// instruction_fetch: pipeline stage 1. Owns the PC, drives the I-cache read
// port and the IF/ID register. It applies decode's redirect, flush and load-use hold.
// It also remembers a redirect that arrives while an I-cache miss is outstanding.
// Optional feature macro: IF_PERF_CNT_EN adds fetch/bubble performance counters.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memory_stall,
    input  logic              PC_write,
    input  logic              PC_src,
    input  logic              IF_flush,
    input  logic [31:0]       branch_address,
    input  logic              ICACHE_stall,
    input  logic [31:0]       ICACHE_rdata,
    output logic              ICACHE_ren,
    output logic [29:0]       ICACHE_addr,
    output logic [31:0]       instruction_1,
    output logic [31:0]       PC_1
`ifdef IF_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_fetch_cnt,
    output logic [CNT_W-1:0]  perf_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MISS  = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc1_reg, pc1_next;
    logic [31:0] pend_reg, pend_next;
    logic        ren_reg;
    logic        write_instr;
    logic        write_nop;
    logic        adv;
    logic [31:0] br_target;
    logic [31:0] pc_plus4;

    // Low two bits of the redirect target are ignored.
    logic unused_br_lsb;
    assign unused_br_lsb = ^branch_address[1:0];

    assign adv         = ~memory_stall & ~PC_write;
    assign br_target   = {branch_address[31:2], 2'b00};
    assign pc_plus4    = pc_reg + 32'd4;
    assign ICACHE_addr = pc_reg[31:2];
    assign ICACHE_ren  = ren_reg;
    assign instruction_1 = instr_reg;
    assign PC_1          = pc1_reg;

    // State, PC, IF/ID and pending-redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_RUN;
            pc_reg    <= RESET_PC;
            instr_reg <= NOP;
            pc1_reg   <= 32'd0;
            pend_reg  <= 32'd0;
            ren_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            pc1_reg   <= pc1_next;
            pend_reg  <= pend_next;
            ren_reg   <= 1'b1;
        end
    end

    // Next-state logic: hit/miss handling, bubbles and redirect tracking.
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        instr_next  = instr_reg;
        pc1_next    = pc1_reg;
        pend_next   = pend_reg;
        write_instr = 1'b0;
        write_nop   = 1'b0;
        case (state_reg)
            S_RUN, S_MISS: begin
                if (!ICACHE_stall) begin
                    state_next = S_RUN;
                    if (adv) begin
                        if (PC_src | IF_flush) begin
                            pc_next    = PC_src ? br_target : pc_plus4;
                            instr_next = NOP;
                            write_nop  = 1'b1;
                        end else begin
                            pc_next     = pc_plus4;
                            instr_next  = ICACHE_rdata;
                            pc1_next    = pc_reg;
                            write_instr = 1'b1;
                        end
                    end
                end else begin
                    state_next = S_MISS;
                    if (adv) begin
                        instr_next = NOP;
                        write_nop  = 1'b1;
                        if (PC_src) begin
                            pend_next  = br_target;
                            state_next = S_REDIR;
                        end
                    end
                end
            end
            S_REDIR: begin
                if (adv) begin
                    instr_next = NOP;
                    write_nop  = 1'b1;
                end
                if (ICACHE_stall) begin
                    // A newer redirect replaces the one still waiting.
                    if (adv && PC_src) begin
                        pend_next = br_target;
                    end
                end else begin
                    // Miss completes: drop its word, jump even under memory_stall.
                    pc_next    = pend_reg;
                    state_next = S_RUN;
                end
            end
            default: state_next = S_RUN;
        endcase
    end

`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_reg;
    logic [CNT_W-1:0] bubble_cnt_reg;

    // Count real instructions and bubbles written into IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (write_instr) fetch_cnt_reg  <= fetch_cnt_reg + 1'b1;
            if (write_nop)   bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_reg;
    assign perf_bubble_cnt = bubble_cnt_reg;
`else
    logic unused_cnt;
    assign unused_cnt = write_instr ^ write_nop;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vectors with literal expectations plus a
// behavioural model compared against the DUT on every falling edge.
module tb_instruction_fetch;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memory_stall = 1'b0;
    logic        PC_write = 1'b0;
    logic        PC_src = 1'b0;
    logic        IF_flush = 1'b0;
    logic [31:0] branch_address = 32'd0;
    logic        ICACHE_stall = 1'b0;
    logic [31:0] ICACHE_rdata;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic [31:0] instruction_1;
    logic [31:0] PC_1;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .memory_stall   (memory_stall),
        .PC_write       (PC_write),
        .PC_src         (PC_src),
        .IF_flush       (IF_flush),
        .branch_address (branch_address),
        .ICACHE_stall   (ICACHE_stall),
        .ICACHE_rdata   (ICACHE_rdata),
        .ICACHE_ren     (ICACHE_ren),
        .ICACHE_addr    (ICACHE_addr),
        .instruction_1  (instruction_1),
        .PC_1           (PC_1)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    // Instruction memory contents by word address.
    function automatic logic [31:0] imem_word(input logic [29:0] a);
        case (a)
            30'd0:   imem_word = 32'h00A0_0093;
            30'd1:   imem_word = 32'h0010_0113;
            30'd2:   imem_word = 32'h0020_81B3;
            30'd3:   imem_word = 32'h4020_8233;
            default: imem_word = {a[19:0], 12'h093};
        endcase
    endfunction

    assign ICACHE_rdata = ICACHE_stall ? 32'hDEAD_BEEF : imem_word(ICACHE_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: PC, IF/ID contents, and an optional remembered redirect.
    logic [31:0] m_pc, m_ir, m_pc1, m_tgt, m_fetch, m_bub;
    logic        m_pend, m_ren;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'd0; m_ir <= NOP_W; m_pc1 <= 32'd0; m_tgt <= 32'd0;
            m_pend <= 1'b0; m_ren <= 1'b0; m_fetch <= 32'd0; m_bub <= 32'd0;
        end else begin : step_model
            logic        adv;
            logic [31:0] tin, pc, ir, pc1, tgt;
            logic        pend;
            logic [31:0] nf, nb;
            adv = !memory_stall && !PC_write;
            tin = {branch_address[31:2], 2'b00};
            pc = m_pc; ir = m_ir; pc1 = m_pc1; tgt = m_tgt; pend = m_pend;
            nf = 32'd0; nb = 32'd0;
            if (m_pend) begin
                if (adv) begin ir = NOP_W; nb = 32'd1; end
                if (ICACHE_stall) begin
                    if (adv && PC_src) tgt = tin;
                end else begin
                    pc = m_tgt; pend = 1'b0;
                end
            end else if (ICACHE_stall) begin
                if (adv) begin
                    ir = NOP_W; nb = 32'd1;
                    if (PC_src) begin pend = 1'b1; tgt = tin; end
                end
            end else if (adv) begin
                if (PC_src || IF_flush) begin
                    pc = PC_src ? tin : m_pc + 32'd4; ir = NOP_W; nb = 32'd1;
                end else begin
                    ir = imem_word(m_pc[31:2]); pc1 = m_pc; pc = m_pc + 32'd4; nf = 32'd1;
                end
            end
            m_pc <= pc; m_ir <= ir; m_pc1 <= pc1; m_tgt <= tgt; m_pend <= pend;
            m_ren <= 1'b1; m_fetch <= m_fetch + nf; m_bub <= m_bub + nb;
        end
    end

    // Compare DUT against the model every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model.addr", {2'b00, ICACHE_addr}, {2'b00, m_pc[31:2]});
            chk("model.instruction_1", instruction_1, m_ir);
            chk("model.PC_1", PC_1, m_pc1);
            chk("model.ren", {31'd0, ICACHE_ren}, {31'd0, m_ren});
`ifdef IF_PERF_CNT_EN
            chk("model.fetch_cnt", perf_fetch_cnt, m_fetch);
            chk("model.bubble_cnt", perf_bubble_cnt, m_bub);
`endif
        end
    end

    task automatic step(input logic ms, input logic pw, input logic src, input logic fl,
                        input logic [31:0] ba, input logic ics);
        memory_stall = ms; PC_write = pw; PC_src = src; IF_flush = fl;
        branch_address = ba; ICACHE_stall = ics;
        @(posedge clk);
        #2;
        $display("step ms=%0b pw=%0b src=%0b fl=%0b ba=%08h ics=%0b -> addr=%08h ir=%08h pc1=%08h",
                 ms, pw, src, fl, ba, ics, ICACHE_addr, instruction_1, PC_1);
    endtask

    task automatic expect_if(input string tag, input logic [29:0] addr,
                             input logic [31:0] ir, input logic [31:0] pc1);
        chk({tag, ".addr"}, {2'b00, ICACHE_addr}, {2'b00, addr});
        chk({tag, ".instruction_1"}, instruction_1, ir);
        chk({tag, ".PC_1"}, PC_1, pc1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        expect_if("reset", 30'd0, NOP_W, 32'd0);
        chk("reset.ren", {31'd0, ICACHE_ren}, 32'd0);
        rst_n = 1'b1;

        // Sequential hits
        step(0, 0, 0, 0, 32'd0, 0); expect_if("hit0", 30'd1, 32'h00A0_0093, 32'd0);
        chk("hit0.ren", {31'd0, ICACHE_ren}, 32'd1);
        step(0, 0, 0, 0, 32'd0, 0); expect_if("hit1", 30'd2, 32'h0010_0113, 32'd4);
        // Load-use hold
        step(0, 1, 0, 0, 32'd0, 0); expect_if("hold", 30'd2, 32'h0010_0113, 32'd4);
        step(0, 0, 0, 0, 32'd0, 0); expect_if("resume", 30'd3, 32'h0020_81B3, 32'd8);
        // Redirects, low bits of target forced to zero
        step(0, 0, 1, 0, 32'h40, 0); expect_if("br40", 30'h10, NOP_W, 32'd8);
        step(0, 0, 1, 0, 32'h0F, 0); expect_if("br0c", 30'h3, NOP_W, 32'd8);
        step(0, 0, 0, 0, 32'd0, 0); expect_if("hitc", 30'h4, 32'h4020_8233, 32'hC);
        // Miss with redirect arriving mid-miss
        step(0, 0, 0, 0, 32'd0, 1); expect_if("miss1", 30'h4, NOP_W, 32'hC);
        step(0, 0, 1, 0, 32'h80, 1); expect_if("miss2", 30'h4, NOP_W, 32'hC);
        step(0, 0, 0, 0, 32'd0, 1); expect_if("miss3", 30'h4, NOP_W, 32'hC);
        step(0, 0, 0, 0, 32'd0, 0); expect_if("redir", 30'h20, NOP_W, 32'hC);
        step(0, 0, 0, 0, 32'd0, 0); expect_if("hit80", 30'h21, 32'h0002_0093, 32'h80);
        step(0, 0, 0, 0, 32'd0, 0); expect_if("hit84", 30'h22, 32'h0002_1093, 32'h84);
        // memory_stall freezes everything, including a redirect request
        for (int i = 0; i < 4; i++) begin
            step(1, 0, (i == 2), 0, 32'h100, 0);
            expect_if("mstall", 30'h22, 32'h0002_1093, 32'h84);
        end
        // Flush without redirect
        step(0, 0, 0, 1, 32'd0, 0); expect_if("flush", 30'h23, NOP_W, 32'h84);
        step(0, 0, 0, 0, 32'd0, 0); expect_if("hit8c", 30'h24, 32'h0002_3093, 32'h8C);
        // PC_write during a miss: no bubble, no redirect captured
        step(0, 1, 1, 0, 32'h200, 1); expect_if("misshold", 30'h24, 32'h0002_3093, 32'h8C);
        step(0, 0, 1, 0, 32'h300, 1); expect_if("missbr1", 30'h24, NOP_W, 32'h8C);
        step(0, 0, 1, 0, 32'h400, 1); expect_if("missbr2", 30'h24, NOP_W, 32'h8C);
        // Pending redirect completes even under memory_stall
        step(1, 0, 0, 0, 32'd0, 0); expect_if("redir_ms", 30'h100, NOP_W, 32'h8C);
        step(0, 0, 0, 0, 32'd0, 0); expect_if("hit400", 30'h101, 32'h0010_0093, 32'h400);
        // PC wrap-around
        step(0, 0, 1, 0, 32'hFFFF_FFFC, 0); expect_if("brtop", 30'h3FFF_FFFF, NOP_W, 32'h400);
        step(0, 0, 0, 0, 32'd0, 0); expect_if("wrap", 30'h0, 32'hFFFF_F093, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 32'd0, 0); expect_if("afterwrap", 30'h1, 32'h00A0_0093, 32'd0);
        // Asynchronous reset mid-run takes effect immediately
        #1 rst_n = 1'b0;
        #1;
        expect_if("async_rst", 30'd0, NOP_W, 32'd0);
        chk("async_rst.ren", {31'd0, ICACHE_ren}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 32'd0, 0); expect_if("post_rst", 30'd1, 32'h00A0_0093, 32'd0);
        step(0, 0, 0, 0, 32'd0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
